logic_unit_arbiter: RTL and testbench

// - Shares one W-bit bitwise logic unit between NUM_REQ requesters.
// - The unit supports AND, OR, NOT, NAND, NOR, XOR and XNOR.
// - A round-robin arbiter grants one request at a time and registers its operands.
// - The result is returned on a valid/ready channel tagged with the requester id.
// - Sits between requesting lab datapaths and a single shared combinational gate array.

---
 rtl/logic_unit_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one W-bit bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) between
//   NUM_REQ requesters. A round-robin arbiter accepts one request at a time,
//   registers its operands, computes the result one cycle later and presents it
//   on a valid/ready result channel tagged with the requester id.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous active-high reset
//   req_valid  in   NUM_REQ      per-requester request valid
//   req_ready  out  NUM_REQ      per-requester accept (one-hot or zero)
//   req_op     in   3*NUM_REQ    opcode, requester i at [3*i+:3]
//   req_a      in   W*NUM_REQ    operand A, requester i at [W*i+:W]
//   req_b      in   W*NUM_REQ    operand B, requester i at [W*i+:W]
//   res_valid  out  1            result valid
//   res_ready  in   1            result consumer ready
//   res_data   out  W            result
//   res_id     out  IDW          requester that issued the op
//   res_err    out  1            illegal opcode flag (opcode 111)
//   op_count   out  16           completed-op counter
//
// Configuration
//   LU_ARB_STATS_EN  when defined, op_count counts completed result handshakes
//                    (saturating at 16'hFFFF); otherwise op_count is tied to 0.

module logic_unit_arbiter #(
  parameter  int W       = 8,
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [3*NUM_REQ-1:0]   req_op,
  input  logic [W*NUM_REQ-1:0]   req_a,
  input  logic [W*NUM_REQ-1:0]   req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_data,
  output logic [IDW-1:0]         res_id,
  output logic                   res_err,
  output logic [15:0]            op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rrPtr;
  logic [2:0]       r_op;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [IDW-1:0]   r_id;
  logic             r_resValid;
  logic [W-1:0]     r_resData;
  logic [IDW-1:0]   r_resId;
  logic             r_resErr;

  logic [IDW-1:0]   w_grantId;
  logic             w_grantFound;
  logic             w_transfer;
  logic [2:0]       w_selOp;
  logic [W-1:0]     w_selA;
  logic [W-1:0]     w_selB;
  logic [W-1:0]     w_aluData;
  logic             w_aluErr;

  // (base + off) mod NUM_REQ without relying on NUM_REQ being a power of two.
  function automatic logic [IDW-1:0] wrapAdd(input logic [IDW-1:0] base,
                                             input int unsigned    off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NUM_REQ)) s = s - 32'(NUM_REQ);
    return IDW'(s);
  endfunction

  // Round-robin search starting at r_rrPtr. Scanning offsets from the far end
  // down to 0 lets the nearest valid requester overwrite any farther one.
  always_comb begin
    w_grantId    = r_rrPtr;
    w_grantFound = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrapAdd(r_rrPtr, 32'(k))]) begin
        w_grantId    = wrapAdd(r_rrPtr, 32'(k));
        w_grantFound = 1'b1;
      end
    end
  end

  // Accept is only offered while idle and out of reset, so at most one bit is set.
  always_comb begin
    req_ready = '0;
    if (!rst && (r_state == S_IDLE) && w_grantFound) begin
      req_ready[w_grantId] = 1'b1;
    end
  end

  assign w_transfer = |(req_valid & req_ready);

  // Select the granted requester's opcode and operands.
  always_comb begin
    w_selOp = '0;
    w_selA  = '0;
    w_selB  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grantId == IDW'(i)) begin
        w_selOp = req_op[3*i +: 3];
        w_selA  = req_a[W*i +: W];
        w_selB  = req_b[W*i +: W];
      end
    end
  end

  // The shared gate array, fed only from the latched operands.
  always_comb begin
    w_aluData = '0;
    w_aluErr  = 1'b0;
    case (r_op)
      3'b000:  w_aluData = r_a & r_b;
      3'b001:  w_aluData = r_a | r_b;
      3'b010:  w_aluData = ~r_a;
      3'b011:  w_aluData = ~(r_a & r_b);
      3'b100:  w_aluData = ~(r_a | r_b);
      3'b101:  w_aluData = r_a ^ r_b;
      3'b110:  w_aluData = ~(r_a ^ r_b);
      default: begin
        w_aluData = '0;
        w_aluErr  = 1'b1;
      end
    endcase
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rrPtr    <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_id       <= '0;
      r_resValid <= 1'b0;
      r_resData  <= '0;
      r_resId    <= '0;
      r_resErr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_transfer) begin
            r_op    <= w_selOp;
            r_a     <= w_selA;
            r_b     <= w_selB;
            r_id    <= w_grantId;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_resData  <= w_aluData;
          r_resErr   <= w_aluErr;
          r_resId    <= r_id;
          r_resValid <= 1'b1;
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            r_resValid <= 1'b0;
            // Next search starts just after the requester that was served.
            r_rrPtr    <= (r_resId == IDW'(NUM_REQ - 1)) ? '0 : r_resId + IDW'(1);
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign res_valid = r_resValid;
  assign res_data  = r_resData;
  assign res_id    = r_resId;
  assign res_err   = r_resErr;

`ifdef LU_ARB_STATS_EN
  logic [15:0] r_opCount;

  // Counts completed result handshakes, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opCount <= '0;
    end else if (r_resValid && res_ready && (r_opCount != 16'hFFFF)) begin
      r_opCount <= r_opCount + 16'd1;
    end
  end

  assign op_count = r_opCount;
`else
  assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter
//   Self-checking bench for logic_unit_arbiter (W=8, NUM_REQ=4). Expected
//   results are queued when a request is accepted and compared by a monitor
//   when the DUT completes a result handshake.

module tb_logic_unit_arbiter;

  localparam int W       = 8;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3*NUM_REQ-1:0] req_op;
  logic [W*NUM_REQ-1:0] req_a;
  logic [W*NUM_REQ-1:0] req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [W-1:0]         res_data;
  logic [IDW-1:0]       res_id;
  logic                 res_err;
  logic [15:0]          op_count;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
    logic       err;
  } expRes_t;

  expRes_t sb[$];
  expRes_t popped;
  int      vectorsApplied = 0;
  int      miscompares    = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.W(W), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err),
    .op_count  (op_count)
  );

  // Reference logic unit: {err, data}.
  function automatic logic [8:0] luModel(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, ~a};
      3'd3:    return {1'b0, ~(a & b)};
      3'd4:    return {1'b0, ~(a | b)};
      3'd5:    return {1'b0, a ^ b};
      3'd6:    return {1'b0, ~(a ^ b)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pushExpected(input logic [7:0] data, input int id, input logic err);
    expRes_t e;
    e.data = data;
    e.id   = 2'(id);
    e.err  = err;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every result handshake is compared with the oldest entry.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_depth", 32'(sb.size()), 32'd1);
      end else begin
        popped = sb.pop_front();
        checkOutput("res_data", res_data, popped.data);
        checkOutput("res_id",   res_id,   popped.id);
        checkOutput("res_err",  res_err,  popped.err);
      end
    end
  end

  // Drives one request from requester rq, waits for its accept, queues the
  // expected result and drops valid. Entered and left at posedge+1.
  task automatic applyStimulus(input int rq, input logic [2:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] expData,
                               input logic expErr);
    bit got;
    req_op[3*rq +: 3] = op;
    req_a[8*rq +: 8]  = a;
    req_b[8*rq +: 8]  = b;
    req_valid[rq]     = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (req_ready[rq]) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (got) begin
      checkOutput("grant_onehot", req_ready, 32'(4'b0001 << rq));
      pushExpected(expData, rq, expErr);
      @(posedge clk);
      #1;
    end else begin
      checkOutput("accept_timeout", req_ready, 32'(4'b0001 << rq));
    end
    req_valid[rq] = 1'b0;
  endtask

  // Waits until every queued result has been consumed.
  task automatic drainResults();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !res_valid) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] t2Exp[8];
    int         order[6];
    logic [2:0] t3Op[4];
    logic [7:0] t3A[4];
    logic [7:0] t3B[4];
    logic [8:0] m;
    int         grants;
    int         lastCyc;
    bit         got;
    logic [2:0] rop;
    logic [7:0] ra;
    logic [7:0] rb;

    t2Exp = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};
    order = '{0, 1, 2, 3, 0, 1};

    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;

    // Reset state, with a request already pending.
    @(posedge clk);
    #1;
    req_op[2:0] = 3'b000;
    req_a[7:0]  = 8'hF0;
    req_b[7:0]  = 8'h3C;
    req_valid   = 4'b0001;
    @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 4'b0000);
    checkOutput("rst_res_valid", res_valid, 1'b0);
    checkOutput("rst_res_data",  res_data,  8'h00);
    checkOutput("rst_res_id",    res_id,    2'd0);
    checkOutput("rst_res_err",   res_err,   1'b0);
    checkOutput("rst_op_count",  op_count,  16'h0000);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    res_ready = 1'b1;

    // T1: single op, check accept and two-cycle latency.
    @(negedge clk);
    checkOutput("t1_req_ready", req_ready, 4'b0001);
    pushExpected(8'h30, 0, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    @(negedge clk);
    checkOutput("t1_valid_t1", res_valid, 1'b0);
    @(negedge clk);
    checkOutput("t1_valid_t2", res_valid, 1'b1);
    drainResults();

    // T2: opcode sweep, rotating through requesters.
    for (int op = 0; op < 8; op++) begin
      applyStimulus(op % 4, 3'(op), 8'hA5, 8'h0F, t2Exp[op], (op == 7));
      drainResults();
    end

    // T3: all requesters pending; grant order and initiation interval.
    for (int i = 0; i < 4; i++) begin
      t3Op[i] = 3'((2 * i + 1) % 7);
      t3A[i]  = 8'(8'h11 * (i + 1));
      t3B[i]  = 8'h3C ^ 8'(i);
      req_op[3*i +: 3] = t3Op[i];
      req_a[8*i +: 8]  = t3A[i];
      req_b[8*i +: 8]  = t3B[i];
    end
    req_valid = 4'b1111;
    grants    = 0;
    lastCyc   = 0;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        checkOutput("t3_order", req_ready, 32'(4'b0001 << order[grants]));
        if (grants > 0) checkOutput("t3_interval", 32'(c - lastCyc), 32'd3);
        lastCyc = c;
        m = luModel(t3Op[order[grants]], t3A[order[grants]], t3B[order[grants]]);
        pushExpected(m[7:0], order[grants], m[8]);
        grants++;
      end
      @(posedge clk);
      #1;
      if (grants == 6) req_valid = 4'b0000;
    end
    req_valid = 4'b0000;
    if (grants < 6) checkOutput("t3_grants", 32'(grants), 32'd6);
    drainResults();

    // T4: backpressure holds the result and blocks new accepts.
    res_ready = 1'b0;
    m = luModel(3'd5, 8'h3C, 8'hC3);
    applyStimulus(3, 3'd5, 8'h3C, 8'hC3, m[7:0], m[8]);
    req_op[2:0]  = 3'd1;
    req_a[7:0]   = 8'h12;
    req_b[7:0]   = 8'h34;
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!got) checkOutput("t4_wait_valid", res_valid, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("t4_hold_valid", res_valid, 1'b1);
      checkOutput("t4_hold_data",  res_data,  m[7:0]);
      checkOutput("t4_hold_id",    res_id,    2'd3);
      checkOutput("t4_hold_ready", req_ready, 4'b0000);
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    res_ready    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_release", res_valid, 1'b0);
    drainResults();

    // T5: reset during EXEC of requester 2 discards it and clears the pointer.
    req_op[6 +: 3] = 3'd1;
    req_a[16 +: 8] = 8'h81;
    req_b[16 +: 8] = 8'h18;
    req_valid      = 4'b0100;
    @(negedge clk);
    checkOutput("t5_grant2", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    rst       = 1'b1;
    sb.delete();
    @(negedge clk);
    checkOutput("t5_rst_ready", req_ready, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t5_no_result", res_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    req_op[3 +: 3] = 3'd3;
    req_a[8 +: 8]  = 8'hCC;
    req_b[8 +: 8]  = 8'hAA;
    req_op[9 +: 3] = 3'd6;
    req_a[24 +: 8] = 8'h0F;
    req_b[24 +: 8] = 8'hFF;
    req_valid      = 4'b1010;
    @(negedge clk);
    checkOutput("t5_rr_reset", req_ready, 4'b0010);
    m = luModel(3'd3, 8'hCC, 8'hAA);
    pushExpected(m[7:0], 1, m[8]);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    m = luModel(3'd6, 8'h0F, 8'hFF);
    applyStimulus(3, 3'd6, 8'h0F, 8'hFF, m[7:0], m[8]);
    drainResults();

    // T6: 300 completed ops from a clean reset.
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      m   = luModel(rop, ra, rb);
      applyStimulus(i % 4, rop, ra, rb, m[7:0], m[8]);
      drainResults();
    end
`ifdef LU_ARB_STATS_EN
    checkOutput("t6_op_count", op_count, 16'h012C);
`else
    checkOutput("t6_op_count", op_count, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
